alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle, handshaked successor to the combinational execute-stage ALU. Parametrised in datapath width and offset width; it registers its result and flags. When compiled in, it adds iterative unsigned multiply and divide. It sits between the register-read stage and writeback, and stalls upstream through a valid/ready handshake while an iterative operation runs.

## Interface
- `WIDTH`, 32, datapath width; must be a power of two and ≥ 8
- `OFFW`, 16, width of the memory-offset field used by ADDOFF
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: operands and `control` valid
- `in_ready` out 1: block can accept; high only in IDLE
- `a` in WIDTH: operand A
- `b` in WIDTH: operand B
- `control` in 4: operation code
- `out_valid` out 1: result and flags valid
- `out_ready` in 1: consumer accepts result
- `result` out WIDTH: registered result
- `zero_flag`, `carry_flag`, `sign_flag`, `overflow_flag` out 1 each: registered flags

## Operation
- Opcodes (operands are captured at accept):
  - 0000 ADD: a+b; carry = bit WIDTH of the sum.
  - 0001 NEG: ~b+1.
  - 0010 AND: a&b.
  - 0011 XOR: a^b.
  - 0100 SLL: a << b[log2(WIDTH)-1:0].
  - 0101 SRL: logical right shift by the same amount.
  - 0110 SRA: arithmetic right shift by the same amount.
  - 0111 PASSA: a.
  - 1000 PASSB: b.
  - 1001 ADDOFF: a + sign-extended b[OFFW-1:0]; carry out as for ADD.
  - 1010 MULU and 1011 DIVU: see Configuration.
  - 1100–1111: result 0, overflow_flag=1 (illegal opcode).
- Flags:
  - zero = (result==0).
  - sign = result[WIDTH-1].
  - overflow for ADD/ADDOFF = operands have the same sign and the result sign differs; 0 for all other legal ops.
  - carry = 0 except where stated.
- FSM:
  - IDLE: on in_valid, capture operands. Single-cycle op → DONE; MULU/DIVU → BUSY.
  - BUSY: count WIDTH iterations, then → DONE.
  - DONE: hold outputs; on out_ready → IDLE.
- Iteration counter is log2(WIDTH)+1 bits wide and is cleared on accept.

## Timing
- Reset (asynchronous, rst_n low): state=IDLE, result=0, all flags=0, out_valid=0, counter=0. in_ready=1 from the first cycle after release.
- Accept occurs on the clock edge where in_valid && in_ready.
- Single-cycle ops: out_valid rises 1 cycle after accept.
- MULU/DIVU: out_valid rises exactly WIDTH+1 cycles after accept.
- result and flags are stable, and identical, for every cycle out_valid is high. They change only on the cycle of a new completion.
- in_ready is low from the cycle after accept until the cycle after the out handshake. Peak throughput is one op per 2 cycles.
- in_valid while not ready: ignored. Inputs need not be held after accept.
- out_ready while out_valid=0: ignored.
- rst_n asserted mid-BUSY or in DONE: operation is abandoned and the outputs return to reset values immediately.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined:
  - MULU: shift-add, one bit per cycle. result = low WIDTH bits of a*b; carry_flag = (high WIDTH bits ≠ 0).
  - DIVU: restoring division, one bit per cycle. result = a/b.
  - DIVU with b=0: result = all ones, overflow_flag=1, still WIDTH+1 cycles.
- Undefined: 1010 and 1011 are treated as illegal opcodes (single cycle, result 0, overflow_flag=1). The BUSY state and iteration datapath are not synthesised.

## Test plan
- Reset, then ADD a=32'hFFFF_FFFF, b=1 → out_valid 1 cycle after accept; result=0, zero=1, carry=1, overflow=0.
- ADD a=32'h7FFF_FFFF, b=1 → result=32'h8000_0000, sign=1, overflow=1, carry=0.
- ADDOFF a=32'h0000_1000, b=32'h0000_FFF0 → result=32'h0000_0FF0, carry=1. Then SRA a=32'h8000_0000, b=32'h0000_0021 → shift by 1, result=32'hC000_0000.
- With macro defined: MULU a=32'h0001_0000, b=32'h0001_0000 → out_valid exactly 33 cycles after accept; result=0, carry=1, zero=1. Then DIVU a=100, b=7 → result=14. Then DIVU b=0 → result=32'hFFFF_FFFF, overflow=1.
- Back-pressure: hold out_ready=0 for 5 cycles after completion → result/flags unchanged, in_ready=0 throughout, and a second in_valid is not accepted until the cycle after out_ready=1.
- Assert rst_n=0 at iteration 10 of a DIVU → out_valid=0 and result=0 asynchronously; after release, in_ready=1 and the next ADD completes normally. Without the macro, control=4'b1010 → 1-cycle completion, result=0, overflow=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with registered result and flags.
// Define ALU_SEQ_MULDIV_EN to add iterative unsigned multiply (1010) and divide (1011).
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int OFFW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             sign_flag,
    output logic             overflow_flag
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    logic             accept;
    logic             iter_op;
    logic             last_iter;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_off;
    logic [WIDTH-1:0] off_ext;
    logic [SHW-1:0]   shamt;

    assign off_ext   = WIDTH'($signed(b[OFFW-1:0]));
    assign shamt     = b[SHW-1:0];
    assign sum_add   = {1'b0, a} + {1'b0, b};
    assign sum_off   = {1'b0, a} + {1'b0, off_ext};
    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        iter_op = 1'b0;
        case (control)
            4'b0000: begin
                res_c   = sum_add[WIDTH-1:0];
                carry_c = sum_add[WIDTH];
                ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0001: res_c = '0 - b;
            4'b0010: res_c = a & b;
            4'b0011: res_c = a ^ b;
            4'b0100: res_c = a << shamt;
            4'b0101: res_c = a >> shamt;
            4'b0110: res_c = $signed(a) >>> shamt;
            4'b0111: res_c = a;
            4'b1000: res_c = b;
            4'b1001: begin
                res_c   = sum_off[WIDTH-1:0];
                carry_c = sum_off[WIDTH];
                ovf_c   = (a[WIDTH-1] == off_ext[WIDTH-1]) && (sum_off[WIDTH-1] != a[WIDTH-1]);
            end
`ifdef ALU_SEQ_MULDIV_EN
            4'b1010, 4'b1011: iter_op = 1'b1;
`endif
            default: ovf_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = iter_op ? BUSY : DONE;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    // hi/lo form the product for MULU and the remainder/quotient pair for DIVU
    localparam int LASTI = WIDTH - 1;

    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;
    logic [WIDTH:0]   madd;
    logic [WIDTH:0]   trial;

    assign last_iter = (cnt == LASTI[SHW:0]);
    assign madd      = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign trial     = {hi, lo[WIDTH-1]} - {1'b0, opnd};

    always_comb begin
        hi_nx = hi;
        lo_nx = lo;
        if (is_div) begin
            hi_nx = trial[WIDTH] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : trial[WIDTH-1:0];
            lo_nx = {lo[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            {hi_nx, lo_nx} = {madd, lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= control[0] ? a : b;
            opnd   <= control[0] ? b : a;
            is_div <= control[0];
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_nx;
            lo  <= lo_nx;
        end
    end
`else
    assign last_iter = 1'b1;
`endif

    // Outputs only move when an operation completes, so they stay frozen through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result        <= '0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            sign_flag     <= 1'b0;
            overflow_flag <= 1'b0;
        end else if (accept && !iter_op) begin
            result        <= res_c;
            zero_flag     <= (res_c == '0);
            carry_flag    <= carry_c;
            sign_flag     <= res_c[WIDTH-1];
            overflow_flag <= ovf_c;
        end
`ifdef ALU_SEQ_MULDIV_EN
        else if ((state == BUSY) && last_iter) begin
            result        <= lo_nx;
            zero_flag     <= (lo_nx == '0);
            carry_flag    <= !is_div && (hi_nx != '0);
            sign_flag     <= lo_nx[WIDTH-1];
            overflow_flag <= is_div && (opnd == '0);
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32, OFFW=16).
// Covers the ALU_SEQ_MULDIV_EN build or the default build depending on the macro.
module tb_alu_seq;
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_NEG    = 4'b0001;
    localparam logic [3:0] OP_AND    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRL    = 4'b0101;
    localparam logic [3:0] OP_SRA    = 4'b0110;
    localparam logic [3:0] OP_PASSA  = 4'b0111;
    localparam logic [3:0] OP_PASSB  = 4'b1000;
    localparam logic [3:0] OP_ADDOFF = 4'b1001;
    localparam logic [3:0] OP_MULU   = 4'b1010;
    localparam logic [3:0] OP_DIVU   = 4'b1011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  control = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        zero_flag;
    logic        carry_flag;
    logic        sign_flag;
    logic        overflow_flag;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .OFFW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .control(control), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .sign_flag(sign_flag), .overflow_flag(overflow_flag)
    );

    // Drives one operation and returns just after the accepting edge, with junk on the inputs
    task automatic start_op(input logic [3:0] ctl, input logic [31:0] va, input logic [31:0] vb);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL start_ready: in_ready=%b expected 1", in_ready);
        else passes++;
        control  = ctl;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0BAD_F00D;
        control  = OP_PASSA;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, zero_flag, carry_flag, sign_flag, overflow_flag} !== 5'b0)
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {out_valid, zero_flag, carry_flag, sign_flag, overflow_flag});
        else passes++;
        checks++;
        if (result !== 32'h0) $display("[TB] FAIL reset_result: got %h expected 0", result);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else passes++;
    endtask

    task automatic test_add();
        int lat;
        start_op(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        wait_done(lat);
        checks++;
        if (lat !== 1) $display("[TB] FAIL add_latency: got %0d expected 1", lat);
        else passes++;
        checks++;
        if (result !== 32'h0) $display("[TB] FAIL add_wrap_result: got %h expected 0", result);
        else passes++;
        checks++;
        if ({zero_flag, carry_flag, sign_flag, overflow_flag} !== 4'b1100)
            $display("[TB] FAIL add_wrap_flags: zcsv=%b expected 1100",
                     {zero_flag, carry_flag, sign_flag, overflow_flag});
        else passes++;
        release_out();

        start_op(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        wait_done(lat);
        checks++;
        if (result !== 32'h8000_0000) $display("[TB] FAIL add_ovf_result: got %h expected 80000000", result);
        else passes++;
        checks++;
        if ({zero_flag, carry_flag, sign_flag, overflow_flag} !== 4'b0011)
            $display("[TB] FAIL add_ovf_flags: zcsv=%b expected 0011",
                     {zero_flag, carry_flag, sign_flag, overflow_flag});
        else passes++;
        release_out();
    endtask

    task automatic test_addoff_shift();
        int lat;
        start_op(OP_ADDOFF, 32'h0000_1000, 32'h0000_FFF0);
        wait_done(lat);
        checks++;
        if (result !== 32'h0000_0FF0) $display("[TB] FAIL addoff_result: got %h expected 00000ff0", result);
        else passes++;
        checks++;
        if ({carry_flag, overflow_flag} !== 2'b10)
            $display("[TB] FAIL addoff_flags: cv=%b expected 10", {carry_flag, overflow_flag});
        else passes++;
        release_out();

        start_op(OP_SRA, 32'h8000_0000, 32'h0000_0021);
        wait_done(lat);
        checks++;
        if (result !== 32'hC000_0000) $display("[TB] FAIL sra_result: got %h expected c0000000", result);
        else passes++;
        checks++;
        if (sign_flag !== 1'b1) $display("[TB] FAIL sra_sign: got %b expected 1", sign_flag);
        else passes++;
        release_out();
    endtask

    task automatic test_logic_ops();
        logic [3:0]  ctl_t [9] = '{OP_NEG, OP_AND, OP_XOR, OP_SLL, OP_SRL, OP_PASSA, OP_PASSB,
                                   4'b1111, 4'b1100};
        logic [31:0] a_t   [9] = '{32'h0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h1, 32'h8000_0000,
                                   32'h1234_5678, 32'h1, 32'h5, 32'h5};
        logic [31:0] b_t   [9] = '{32'h5, 32'hFF00_FF00, 32'hFF00_FF00, 32'h24, 32'h4,
                                   32'h9, 32'hCAFE_BABE, 32'h5, 32'h5};
        logic [31:0] exp_t [9] = '{32'hFFFF_FFFB, 32'hF000_F000, 32'h0FF0_0FF0, 32'h10,
                                   32'h0800_0000, 32'h1234_5678, 32'hCAFE_BABE, 32'h0, 32'h0};
        logic        ovf_t [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 9; i++) begin
            start_op(ctl_t[i], a_t[i], b_t[i]);
            wait_done(lat);
            checks++;
            if (result !== exp_t[i])
                $display("[TB] FAIL op%0d_result: control=%b got %h expected %h", i, ctl_t[i], result, exp_t[i]);
            else passes++;
            checks++;
            if ({carry_flag, overflow_flag} !== {1'b0, ovf_t[i]})
                $display("[TB] FAIL op%0d_flags: cv=%b expected %b", i, {carry_flag, overflow_flag}, {1'b0, ovf_t[i]});
            else passes++;
            release_out();
        end
    endtask

`ifdef ALU_SEQ_MULDIV_EN
    task automatic test_muldiv();
        int lat;
        start_op(OP_MULU, 32'h0001_0000, 32'h0001_0000);
        wait_done(lat);
        checks++;
        if (lat !== 33) $display("[TB] FAIL mulu_latency: got %0d expected 33", lat);
        else passes++;
        checks++;
        if (result !== 32'h0) $display("[TB] FAIL mulu_result: got %h expected 0", result);
        else passes++;
        checks++;
        if ({zero_flag, carry_flag, overflow_flag} !== 3'b110)
            $display("[TB] FAIL mulu_flags: zcv=%b expected 110", {zero_flag, carry_flag, overflow_flag});
        else passes++;
        release_out();

        start_op(OP_MULU, 32'd12345, 32'd678);
        wait_done(lat);
        checks++;
        if ({result, carry_flag} !== {32'd8369910, 1'b0})
            $display("[TB] FAIL mulu_small: got %0d c=%b expected 8369910 c=0", result, carry_flag);
        else passes++;
        release_out();

        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat);
        checks++;
        if (lat !== 33) $display("[TB] FAIL divu_latency: got %0d expected 33", lat);
        else passes++;
        checks++;
        if ({result, overflow_flag} !== {32'd14, 1'b0})
            $display("[TB] FAIL divu_result: got %0d v=%b expected 14 v=0", result, overflow_flag);
        else passes++;
        release_out();

        start_op(OP_DIVU, 32'd55, 32'd0);
        wait_done(lat);
        checks++;
        if (lat !== 33) $display("[TB] FAIL divu0_latency: got %0d expected 33", lat);
        else passes++;
        checks++;
        if ({result, overflow_flag} !== {32'hFFFF_FFFF, 1'b1})
            $display("[TB] FAIL divu0_result: got %h v=%b expected ffffffff v=1", result, overflow_flag);
        else passes++;
        release_out();
    endtask
`else
    task automatic test_illegal_muldiv();
        int lat;
        start_op(OP_MULU, 32'h3, 32'h4);
        wait_done(lat);
        checks++;
        if (lat !== 1) $display("[TB] FAIL mul_off_latency: got %0d expected 1", lat);
        else passes++;
        checks++;
        if ({result, overflow_flag} !== {32'h0, 1'b1})
            $display("[TB] FAIL mul_off_result: got %h v=%b expected 0 v=1", result, overflow_flag);
        else passes++;
        release_out();
        start_op(OP_DIVU, 32'h9, 32'h3);
        wait_done(lat);
        checks++;
        if ({lat, result, overflow_flag} !== {32'd1, 32'h0, 1'b1})
            $display("[TB] FAIL div_off: lat=%0d got %h v=%b expected lat=1 0 v=1", lat, result, overflow_flag);
        else passes++;
        release_out();
    endtask
`endif

    task automatic test_back_to_back();
        int lat;
        start_op(OP_ADD, 32'd3, 32'd4);
        wait_done(lat);
        checks++;
        if (result !== 32'd7) $display("[TB] FAIL bp_first: got %0d expected 7", result);
        else passes++;
        control  = OP_ADD;
        a        = 32'd10;
        b        = 32'd20;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'd7})
                $display("[TB] FAIL bp_hold%0d: ov=%b ir=%b res=%0d expected ov=1 ir=0 res=7",
                         k, out_valid, in_ready, result);
            else passes++;
        end
        release_out();
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("[TB] FAIL bp_release: ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready);
        else passes++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, result} !== {1'b1, 32'd30})
            $display("[TB] FAIL bp_second: ov=%b res=%0d expected ov=1 res=30", out_valid, result);
        else passes++;
        release_out();
    endtask

    task automatic test_async_reset();
        int lat;
        start_op(OP_ADD, 32'd9, 32'd9);
        wait_done(lat);
        checks++;
        if (result !== 32'd18) $display("[TB] FAIL ar_pre: got %0d expected 18", result);
        else passes++;
`ifdef ALU_SEQ_MULDIV_EN
        release_out();
        start_op(OP_DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b00)
            $display("[TB] FAIL ar_busy: ov=%b ir=%b expected 00", out_valid, in_ready);
        else passes++;
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, result} !== {1'b0, 32'h0})
            $display("[TB] FAIL ar_clear: ov=%b res=%h expected ov=0 res=0", out_valid, result);
        else passes++;
        checks++;
        if ({zero_flag, carry_flag, sign_flag, overflow_flag} !== 4'b0)
            $display("[TB] FAIL ar_flags: zcsv=%b expected 0000",
                     {zero_flag, carry_flag, sign_flag, overflow_flag});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("[TB] FAIL ar_after: ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready);
        else passes++;
        start_op(OP_ADD, 32'd2, 32'd3);
        wait_done(lat);
        checks++;
        if ({lat, result} !== {32'd1, 32'd5})
            $display("[TB] FAIL ar_next_add: lat=%0d res=%0d expected lat=1 res=5", lat, result);
        else passes++;
        release_out();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_addoff_shift();
        test_logic_ops();
`ifdef ALU_SEQ_MULDIV_EN
        test_muldiv();
`else
        test_illegal_muldiv();
`endif
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
